// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control FSM: fetch, decode, ALU/data-memory sequencing,
// branch resolution and trap reporting for illegal opcodes and handshake timeouts.
module mc_ctrl_fsm #(
    parameter int ALU_TIMEOUT = 16,
    parameter int MEM_TIMEOUT = 16,
    parameter int ALU_OP_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                instr_valid,
    input  logic                alu_valid,
    input  logic                br_eq,
    input  logic                br_lt,
    input  logic                br_ltu,
    input  logic                dm_ready,
    input  logic                trap_ack,
    output logic                if_req,
    output logic                rf_re,
    output logic                rf_we,
    output logic [1:0]          a_sel,
    output logic                b_sel,
    output logic [2:0]          imm_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_en,
    output logic                dm_re,
    output logic                dm_we,
    output logic [2:0]          ls_op,
    output logic [1:0]          wb_sel,
    output logic                pc_we,
    output logic [1:0]          pc_sel,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [5:0]          fsm_state
);

    // Handshakes: each of instr_valid, alu_valid and dm_ready is a one-cycle
    // completion pulse sampled only while the FSM is in the matching state
    // (FETCH, EXEC, MEM); the request outputs stay high until that cycle.

    typedef enum logic [5:0] {
        S_FETCH  = 6'b000001,
        S_DECODE = 6'b000010,
        S_EXEC   = 6'b000100,
        S_MEM    = 6'b001000,
        S_WB     = 6'b010000,
        S_TRAP   = 6'b100000
    } state_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(5'b00001);
    localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(5'b00011);
    localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(5'b01010);
    localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(5'b01100);
    localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(5'b01101);
    localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(5'b01110);
    localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(5'b01111);
    localparam logic [ALU_OP_W-1:0] OP_SRA  = ALU_OP_W'(5'b10000);
    localparam logic [ALU_OP_W-1:0] OP_SLT  = ALU_OP_W'(5'b10001);
    localparam logic [ALU_OP_W-1:0] OP_SLTU = ALU_OP_W'(5'b10010);

    localparam int TMAX  = (ALU_TIMEOUT > MEM_TIMEOUT) ? ALU_TIMEOUT : MEM_TIMEOUT;
    localparam int CNT_W = (TMAX < 2) ? 1 : $clog2(TMAX);

    state_t             state, next;
    logic [31:0]        ir;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         cause_q;
    logic               trap_load;
    logic [1:0]         trap_code;

    logic [6:0]          opcode;
    logic [2:0]          f3;
    logic [6:0]          f7;
    logic                is_load, is_store, is_branch, is_lui, is_jal, is_jalr;
    logic [2:0]          dec_imm;
    logic [1:0]          dec_a;
    logic                dec_b;
    logic [ALU_OP_W-1:0] dec_op;
    logic [2:0]          dec_ls;
    logic                illegal;
    logic                taken;
    logic                alu_to, mem_to;
    logic                unused_ir;

    assign opcode    = ir[6:0];
    assign f3        = ir[14:12];
    assign f7        = ir[31:25];
    assign unused_ir = ^{ir[24:15], ir[11:7]};

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BR);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);

    // Limit reached this cycle; the handshake itself is checked first in the FSM.
    assign alu_to = (ALU_TIMEOUT != 0) && (cnt == CNT_W'(ALU_TIMEOUT - 1));
    assign mem_to = (MEM_TIMEOUT != 0) && (cnt == CNT_W'(MEM_TIMEOUT - 1));

    function automatic logic [ALU_OP_W-1:0] alu_fn(input logic [2:0] fn, input logic alt);
        case (fn)
            3'b000:  alu_fn = alt ? OP_SUB : OP_ADD;
            3'b001:  alu_fn = OP_SLL;
            3'b010:  alu_fn = OP_SLT;
            3'b011:  alu_fn = OP_SLTU;
            3'b100:  alu_fn = OP_XOR;
            3'b101:  alu_fn = alt ? OP_SRA : OP_SRL;
            3'b110:  alu_fn = OP_OR;
            default: alu_fn = OP_AND;
        endcase
    endfunction

    always_comb begin
        dec_imm = 3'b000;
        dec_a   = 2'b00;
        dec_b   = 1'b1;
        dec_op  = OP_ADD;
        dec_ls  = 3'b000;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_b  = 1'b0;
                dec_op = alu_fn(f3, f7[5]);
                if (!(f7 == 7'h00 || f7 == 7'h20) ||
                    (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101))
                    illegal = 1'b1;
            end
            OPC_OPIMM: begin
                dec_imm = 3'b001;
                dec_op  = alu_fn(f3, (f3 == 3'b101) && f7[5]);
                if ((f3 == 3'b001 && f7 != 7'h00) ||
                    (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20))
                    illegal = 1'b1;
            end
            OPC_LOAD: begin
                dec_imm = 3'b001;
                case (f3)
                    3'b000:  dec_ls = 3'b100;
                    3'b001:  dec_ls = 3'b101;
                    3'b010:  dec_ls = 3'b000;
                    3'b100:  dec_ls = 3'b110;
                    3'b101:  dec_ls = 3'b111;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_imm = 3'b010;
                case (f3)
                    3'b000:  dec_ls = 3'b001;
                    3'b001:  dec_ls = 3'b010;
                    3'b010:  dec_ls = 3'b011;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_BR: begin
                dec_imm = 3'b011;
                dec_a   = 2'b01;
                if (f3 == 3'b010 || f3 == 3'b011)
                    illegal = 1'b1;
            end
            OPC_LUI:   dec_imm = 3'b100;
            OPC_AUIPC: begin
                dec_imm = 3'b100;
                dec_a   = 2'b01;
            end
            OPC_JAL: begin
                dec_imm = 3'b101;
                dec_a   = 2'b01;
            end
            OPC_JALR: begin
                dec_imm = 3'b001;
                if (f3 != 3'b000)
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;   // includes FENCE and SYSTEM
        endcase
    end

    always_comb begin
        case (f3)
            3'b000:  taken = br_eq;
            3'b001:  taken = !br_eq;
            3'b100:  taken = br_lt;
            3'b101:  taken = !br_lt;
            3'b110:  taken = br_ltu;
            3'b111:  taken = !br_ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next      = state;
        trap_code = 2'b00;
        if_req    = 1'b0;
        rf_re     = 1'b0;
        rf_we     = 1'b0;
        a_sel     = 2'b00;
        b_sel     = 1'b0;
        imm_sel   = 3'b000;
        alu_op    = '0;
        alu_en    = 1'b0;
        dm_re     = 1'b0;
        dm_we     = 1'b0;
        ls_op     = 3'b000;
        wb_sel    = 2'b00;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        trap      = 1'b0;
        case (state)
            S_FETCH: begin
                if_req = 1'b1;
                if (instr_valid)
                    next = S_DECODE;
            end
            S_DECODE: begin
                rf_re   = 1'b1;
                imm_sel = dec_imm;
                if (illegal) begin
                    next      = S_TRAP;
                    trap_code = 2'b01;
                end else if (is_lui) begin
                    next = S_WB;
                end else begin
                    next = S_EXEC;
                end
            end
            S_EXEC: begin
                rf_re  = 1'b1;
                alu_en = 1'b1;
                a_sel  = dec_a;
                b_sel  = dec_b;
                alu_op = dec_op;
                if (alu_valid) begin
                    if (is_load || is_store) begin
                        next = S_MEM;
                    end else if (is_branch) begin
                        pc_we  = 1'b1;
                        pc_sel = taken ? 2'b01 : 2'b00;
                        next   = S_FETCH;
                    end else begin
                        next = S_WB;
                    end
                end else if (alu_to) begin
                    next      = S_TRAP;
                    trap_code = 2'b11;
                end
            end
            S_MEM: begin
                dm_re = is_load;
                dm_we = is_store;
                ls_op = dec_ls;
                if (dm_ready) begin
                    if (is_load) begin
                        next = S_WB;
                    end else begin
                        pc_we = 1'b1;
                        next  = S_FETCH;
                    end
                end else if (mem_to) begin
                    next      = S_TRAP;
                    trap_code = 2'b10;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                wb_sel = is_load ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : is_lui ? 2'b11 : 2'b00;
                pc_sel = is_jal ? 2'b01 : is_jalr ? 2'b10 : 2'b00;
                next   = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
                if (trap_ack)
                    next = S_FETCH;
            end
            default: next = S_FETCH;
        endcase
    end

    assign trap_load  = (next == S_TRAP) && (state != S_TRAP);
    assign trap_cause = cause_q;
    assign fsm_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            ir      <= '0;
            cnt     <= '0;
            cause_q <= 2'b00;
        end else begin
            state <= next;
            if (state == S_FETCH && instr_valid)
                ir <= instr;
            if (next != state && (next == S_EXEC || next == S_MEM))
                cnt <= '0;
            else if ((state == S_EXEC && !alu_valid) || (state == S_MEM && !dm_ready))
                cnt <= cnt + 1'b1;
            if (state == S_TRAP && trap_ack)
                cause_q <= 2'b00;
            else if (trap_load)
                cause_q <= trap_code;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: each cycle's expected output bundle is queued
// as the inputs are driven and compared against the DUT mid-cycle.
module tb_mc_ctrl_fsm;

    localparam logic [5:0] ST_FETCH  = 6'b000001;
    localparam logic [5:0] ST_DECODE = 6'b000010;
    localparam logic [5:0] ST_EXEC   = 6'b000100;
    localparam logic [5:0] ST_MEM    = 6'b001000;
    localparam logic [5:0] ST_WB     = 6'b010000;
    localparam logic [5:0] ST_TRAP   = 6'b100000;

    localparam logic [4:0] ADD = 5'b00001;
    localparam logic [4:0] SRA = 5'b10000;

    typedef struct packed {
        logic [5:0] st;
        logic       if_req;
        logic       rf_re;
        logic       rf_we;
        logic [1:0] a_sel;
        logic       b_sel;
        logic [2:0] imm_sel;
        logic [4:0] alu_op;
        logic       alu_en;
        logic       dm_re;
        logic       dm_we;
        logic [2:0] ls_op;
        logic [1:0] wb_sel;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       trap;
        logic [1:0] trap_cause;
    } outs_t;

    localparam int W = $bits(outs_t);

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid, alu_valid, br_eq, br_lt, br_ltu, dm_ready, trap_ack;
    logic        if_req, rf_re, rf_we, b_sel, alu_en, dm_re, dm_we, pc_we, trap;
    logic [1:0]  a_sel, wb_sel, pc_sel, trap_cause;
    logic [2:0]  imm_sel, ls_op;
    logic [4:0]  alu_op;
    logic [5:0]  fsm_state;

    logic [W-1:0] exp_q[$];
    int           errors = 0;
    int           checks = 0;
    outs_t        obs;

    // clock / reset
    always #5 clk = ~clk;

    mc_ctrl_fsm #(.ALU_TIMEOUT(16), .MEM_TIMEOUT(16), .ALU_OP_W(5)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .alu_valid(alu_valid), .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
        .dm_ready(dm_ready), .trap_ack(trap_ack), .if_req(if_req), .rf_re(rf_re),
        .rf_we(rf_we), .a_sel(a_sel), .b_sel(b_sel), .imm_sel(imm_sel),
        .alu_op(alu_op), .alu_en(alu_en), .dm_re(dm_re), .dm_we(dm_we),
        .ls_op(ls_op), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
        .trap(trap), .trap_cause(trap_cause), .fsm_state(fsm_state)
    );

    assign obs = {fsm_state, if_req, rf_re, rf_we, a_sel, b_sel, imm_sel, alu_op,
                  alu_en, dm_re, dm_we, ls_op, wb_sel, pc_we, pc_sel, trap, trap_cause};

    // expected output bundles per state
    function automatic outs_t e_fetch();
        outs_t e = '0;
        e.st = ST_FETCH; e.if_req = 1'b1;
        return e;
    endfunction

    function automatic outs_t e_decode(input logic [2:0] imm);
        outs_t e = '0;
        e.st = ST_DECODE; e.rf_re = 1'b1; e.imm_sel = imm;
        return e;
    endfunction

    function automatic outs_t e_exec(input logic [1:0] a, input logic b, input logic [4:0] op,
                                     input logic pcwe, input logic [1:0] pcsel);
        outs_t e = '0;
        e.st = ST_EXEC; e.rf_re = 1'b1; e.alu_en = 1'b1;
        e.a_sel = a; e.b_sel = b; e.alu_op = op; e.pc_we = pcwe; e.pc_sel = pcsel;
        return e;
    endfunction

    function automatic outs_t e_mem(input logic re, input logic we, input logic [2:0] ls,
                                    input logic pcwe);
        outs_t e = '0;
        e.st = ST_MEM; e.dm_re = re; e.dm_we = we; e.ls_op = ls; e.pc_we = pcwe;
        return e;
    endfunction

    function automatic outs_t e_wb(input logic [1:0] wb, input logic [1:0] pcsel);
        outs_t e = '0;
        e.st = ST_WB; e.rf_we = 1'b1; e.pc_we = 1'b1; e.wb_sel = wb; e.pc_sel = pcsel;
        return e;
    endfunction

    function automatic outs_t e_trap(input logic [1:0] cause);
        outs_t e = '0;
        e.st = ST_TRAP; e.trap = 1'b1; e.trap_cause = cause;
        return e;
    endfunction

    // one clock cycle: queue expectation, compare mid-cycle, advance
    task automatic cyc(input outs_t e, input string tag);
        logic [W-1:0] want;
        exp_q.push_back(W'(e));
        #1;
        want = exp_q.pop_front();
        checks++;
        assert (W'(obs) === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, W'(obs), want);
        end
        @(negedge clk);
    endtask

    // random idle cycles in FETCH, then the instruction is handed over
    task automatic fetch_instr(input logic [31:0] word);
        int n;
        n = $urandom_range(0, 2);
        instr_valid = 1'b0;
        repeat (n) cyc(e_fetch(), "fetch_idle");
        instr       = word;
        instr_valid = 1'b1;
        cyc(e_fetch(), "fetch");
        instr_valid = 1'b0;
        instr       = $urandom;
    endtask

    initial begin
        rst = 1'b1; instr = '0; instr_valid = 1'b0; alu_valid = 1'b0;
        br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0; dm_ready = 1'b0; trap_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        cyc(e_fetch(), "reset_state");

        // add x3,x1,x2
        fetch_instr(32'h002081B3);
        alu_valid = 1'b1;
        cyc(e_decode(3'b000), "add_decode");
        cyc(e_exec(2'b00, 1'b0, ADD, 1'b0, 2'b00), "add_exec");
        alu_valid = 1'b0;
        cyc(e_wb(2'b00, 2'b00), "add_wb");

        // lw x5,8(x1), dm_ready after 3 wait cycles
        fetch_instr(32'h0080A283);
        alu_valid = 1'b1;
        cyc(e_decode(3'b001), "lw_decode");
        cyc(e_exec(2'b00, 1'b1, ADD, 1'b0, 2'b00), "lw_exec");
        alu_valid = 1'b0;
        repeat (3) cyc(e_mem(1'b1, 1'b0, 3'b000, 1'b0), "lw_mem_wait");
        dm_ready = 1'b1;
        cyc(e_mem(1'b1, 1'b0, 3'b000, 1'b0), "lw_mem_done");
        dm_ready = 1'b0;
        cyc(e_wb(2'b01, 2'b00), "lw_wb");

        // beq taken, one ALU wait cycle
        fetch_instr(32'h00208463);
        cyc(e_decode(3'b011), "beq_decode");
        cyc(e_exec(2'b01, 1'b1, ADD, 1'b0, 2'b00), "beq_alu_wait");
        alu_valid = 1'b1; br_eq = 1'b1;
        cyc(e_exec(2'b01, 1'b1, ADD, 1'b1, 2'b01), "beq_taken");
        alu_valid = 1'b0; br_eq = 1'b0;
        cyc(e_fetch(), "beq_back_to_fetch");

        // beq not taken
        fetch_instr(32'h00208463);
        alu_valid = 1'b1;
        cyc(e_decode(3'b011), "beq_nt_decode");
        cyc(e_exec(2'b01, 1'b1, ADD, 1'b1, 2'b00), "beq_not_taken");

        // bne taken when operands differ
        fetch_instr(32'h00209463);
        cyc(e_decode(3'b011), "bne_decode");
        cyc(e_exec(2'b01, 1'b1, ADD, 1'b1, 2'b01), "bne_taken");
        alu_valid = 1'b0;

        // sw x2,4(x1) with immediate dm_ready retires in MEM
        fetch_instr(32'h0020A223);
        alu_valid = 1'b1;
        cyc(e_decode(3'b010), "sw_decode");
        cyc(e_exec(2'b00, 1'b1, ADD, 1'b0, 2'b00), "sw_exec");
        alu_valid = 1'b0; dm_ready = 1'b1;
        cyc(e_mem(1'b0, 1'b1, 3'b011, 1'b1), "sw_mem_retire");
        dm_ready = 1'b0;
        cyc(e_fetch(), "sw_back_to_fetch");

        // sw with dm_ready never arriving: MEM timeout
        fetch_instr(32'h0020A223);
        alu_valid = 1'b1;
        cyc(e_decode(3'b010), "swto_decode");
        cyc(e_exec(2'b00, 1'b1, ADD, 1'b0, 2'b00), "swto_exec");
        alu_valid = 1'b0;
        repeat (16) cyc(e_mem(1'b0, 1'b1, 3'b011, 1'b0), "swto_mem_wait");
        cyc(e_trap(2'b10), "swto_trap");
        trap_ack = 1'b1;
        cyc(e_trap(2'b10), "swto_trap_ack");
        trap_ack = 1'b0;
        cyc(e_fetch(), "swto_after_ack");

        // all-zero word is illegal; reset clears the trap
        fetch_instr(32'h00000000);
        cyc(e_decode(3'b000), "zero_decode");
        cyc(e_trap(2'b01), "zero_trap");
        cyc(e_trap(2'b01), "zero_trap_hold");
        rst = 1'b1;
        cyc(e_trap(2'b01), "zero_trap_rst");
        rst = 1'b0;
        cyc(e_fetch(), "zero_after_rst");

        // funct7=0100000 with funct3=001 is illegal
        fetch_instr(32'h40001033);
        cyc(e_decode(3'b000), "badf7_decode");
        trap_ack = 1'b1;
        cyc(e_trap(2'b01), "badf7_trap");
        trap_ack = 1'b0;
        cyc(e_fetch(), "badf7_after_ack");

        // lui x5,0x12345 skips EXEC
        fetch_instr(32'h123452B7);
        cyc(e_decode(3'b100), "lui_decode");
        cyc(e_wb(2'b11, 2'b00), "lui_wb");

        // addi x1,x1,1 with alu_valid never arriving: ALU timeout
        fetch_instr(32'h00108093);
        cyc(e_decode(3'b001), "addito_decode");
        repeat (16) cyc(e_exec(2'b00, 1'b1, ADD, 1'b0, 2'b00), "addito_exec_wait");
        cyc(e_trap(2'b11), "addito_trap");
        trap_ack = 1'b1;
        cyc(e_trap(2'b11), "addito_trap_ack");
        trap_ack = 1'b0;

        // alu_valid on the limit cycle wins over the timeout
        cyc(e_fetch(), "addi_fetch_idle");
        fetch_instr(32'h00108093);
        cyc(e_decode(3'b001), "addi_decode");
        repeat (15) cyc(e_exec(2'b00, 1'b1, ADD, 1'b0, 2'b00), "addi_exec_wait");
        alu_valid = 1'b1;
        cyc(e_exec(2'b00, 1'b1, ADD, 1'b0, 2'b00), "addi_exec_limit");
        alu_valid = 1'b0;
        cyc(e_wb(2'b00, 2'b00), "addi_wb");

        // jalr x1,0(x1)
        fetch_instr(32'h000080E7);
        alu_valid = 1'b1;
        cyc(e_decode(3'b001), "jalr_decode");
        cyc(e_exec(2'b00, 1'b1, ADD, 1'b0, 2'b00), "jalr_exec");
        cyc(e_wb(2'b10, 2'b10), "jalr_wb");

        // jal x1,8
        fetch_instr(32'h008000EF);
        cyc(e_decode(3'b101), "jal_decode");
        cyc(e_exec(2'b01, 1'b1, ADD, 1'b0, 2'b00), "jal_exec");
        cyc(e_wb(2'b10, 2'b01), "jal_wb");

        // sra x3,x1,x2
        fetch_instr(32'h4020D1B3);
        cyc(e_decode(3'b000), "sra_decode");
        cyc(e_exec(2'b00, 1'b0, SRA, 1'b0, 2'b00), "sra_exec");
        cyc(e_wb(2'b00, 2'b00), "sra_wb");

        // reset mid-MEM abandons the load
        fetch_instr(32'h0080A283);
        cyc(e_decode(3'b001), "lwrst_decode");
        cyc(e_exec(2'b00, 1'b1, ADD, 1'b0, 2'b00), "lwrst_exec");
        alu_valid = 1'b0;
        cyc(e_mem(1'b1, 1'b0, 3'b000, 1'b0), "lwrst_mem");
        rst = 1'b1;
        cyc(e_mem(1'b1, 1'b0, 3'b000, 1'b0), "lwrst_mem_rst");
        rst = 1'b0;
        cyc(e_fetch(), "lwrst_after_rst");
        cyc(e_fetch(), "lwrst_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
